// File: rtl/cpu_clk_pkg.sv
// Shared state encoding and divider width for cpu_clock_ctrl and its tests.
package cpu_clk_pkg;

  localparam int DIV_W = 32;

  // state     | meaning
  // RUN       | divider issues cpu_en every DIVn clks
  // WAIT_STEP | one cpu_en per debounced step press
  // HALTED    | syscall reached; only a go press releases the core
  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_WAIT_STEP = 2'b01,
    ST_HALTED    = 2'b10
  } state_e;

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and one-clk rising-edge pulse.
// A level is accepted once the synchronised input differs from it for DEB_CYCLES clks.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run/step/halt sequencing of the MIPS core step enable plus display scan strobe.
// Define CPU_CLOCK_CTRL_CYCLE_COUNT_EN to build the saturating instr_count counter.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV0       = 50_000_000,
  parameter int unsigned DIV1       = 5_000_000,
  parameter int unsigned DIV2       = 500_000,
  parameter int unsigned DIV3       = 4,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  div_sel,
  input  logic        step_mode,
  input  logic        step_btn,
  input  logic        go_btn,
  input  logic        halt_in,
  output logic        cpu_en,
  output logic        scan_en,
  output logic [1:0]  state_o,
  output logic [31:0] instr_count
);

  localparam logic [DIV_W-1:0] DIV0_MAX = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] DIV1_MAX = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] DIV2_MAX = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] DIV3_MAX = DIV_W'(DIV3 - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE = SCAN_W'(1);

  logic             r_mode_s1;
  logic             r_mode_s2;
  logic [1:0]       r_div_s1;
  logic [1:0]       r_div_s2;
  logic [1:0]       r_div_prev;

  state_e           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_cpu_en;
  logic             r_resume;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_scan_en;

  logic             w_step_rise;
  logic             w_step_level;
  logic             w_go_rise;
  logic             w_go_level;
  logic             w_unused_levels;
  logic [DIV_W-1:0] w_div_max;
  logic             w_halt_hit;

  // Switch synchronisers carry no reset: the switch values present at reset
  // release, not a forced default, set the run rate and start mode.
  always_ff @(posedge clk) begin
    r_mode_s1  <= step_mode;
    r_mode_s2  <= r_mode_s1;
    r_div_s1   <= div_sel;
    r_div_s2   <= r_div_s1;
    r_div_prev <= r_div_s2;
  end

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (step_btn),
    .btn_level (w_step_level),
    .btn_rise  (w_step_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (go_btn),
    .btn_level (w_go_level),
    .btn_rise  (w_go_rise)
  );

  assign w_unused_levels = w_step_level ^ w_go_level;

  always_comb begin
    w_div_max = DIV0_MAX;
    case (r_div_s2)
      2'd1:    w_div_max = DIV1_MAX;
      2'd2:    w_div_max = DIV2_MAX;
      2'd3:    w_div_max = DIV3_MAX;
      default: w_div_max = DIV0_MAX;
    endcase
  end

  // The resume pulse executes the syscall itself, so its halt_in must not re-halt.
  assign w_halt_hit = r_cpu_en & halt_in & ~r_resume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_div_cnt <= '0;
      r_cpu_en  <= 1'b0;
      r_resume  <= 1'b0;
    end else begin
      r_cpu_en <= 1'b0;
      r_resume <= 1'b0;
      if (w_halt_hit) begin
        r_state   <= ST_HALTED;
        r_div_cnt <= '0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (r_mode_s2) begin
              r_state   <= ST_WAIT_STEP;
              r_div_cnt <= '0;
            end else if (r_div_s2 != r_div_prev) begin
              r_div_cnt <= '0;
            end else if (r_div_cnt >= w_div_max) begin
              r_div_cnt <= '0;
              r_cpu_en  <= 1'b1;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_ONE;
            end
          end
          ST_WAIT_STEP: begin
            r_div_cnt <= '0;
            if (w_step_rise) begin
              r_cpu_en <= 1'b1;
            end
            if (!r_mode_s2) begin
              r_state <= ST_RUN;
            end
          end
          ST_HALTED: begin
            r_div_cnt <= '0;
            if (w_go_rise) begin
              r_cpu_en <= 1'b1;
              r_resume <= 1'b1;
              r_state  <= r_mode_s2 ? ST_WAIT_STEP : ST_RUN;
            end
          end
          default: begin
            r_state   <= ST_RUN;
            r_div_cnt <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_en  <= 1'b0;
    end else begin
      r_scan_en <= (r_scan_cnt == SCAN_MAX);
      if (r_scan_cnt == SCAN_MAX) begin
        r_scan_cnt <= '0;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_ONE;
      end
    end
  end

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (r_cpu_en && (r_instr_cnt != 32'hFFFF_FFFF)) begin
      r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign instr_count = r_instr_cnt;
`else
  assign instr_count = 32'd0;
`endif

  assign cpu_en  = r_cpu_en;
  assign scan_en = r_scan_en;
  assign state_o = r_state;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: free-run, step, halt/resume, rate change, async reset, go+step.
// Expected instr_count follows CPU_CLOCK_CTRL_CYCLE_COUNT_EN when it is defined for the build.
module tb_cpu_clock_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  div_sel;
  logic        step_mode;
  logic        step_btn;
  logic        go_btn;
  logic        halt_in;
  logic        cpu_en;
  logic        scan_en;
  logic [1:0]  state_o;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;
  int win_pulses;
  int win_first;
  int win_scan;
  int g_en = 0;
  int n_consec = 0;
  logic last_en = 1'b0;
  int p;

  cpu_clock_ctrl #(
    .DIV0(16), .DIV1(8), .DIV2(6), .DIV3(4),
    .SCAN_DIV(5), .DEB_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_sel     (div_sel),
    .step_mode   (step_mode),
    .step_btn    (step_btn),
    .go_btn      (go_btn),
    .halt_in     (halt_in),
    .cpu_en      (cpu_en),
    .scan_en     (scan_en),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clks, sampling outputs on each falling edge.
  task automatic cycles(input int n);
    win_pulses = 0;
    win_first  = 0;
    win_scan   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        win_pulses++;
        g_en++;
        if (win_first == 0) win_first = i;
        if (last_en) n_consec++;
      end
      if (scan_en) win_scan++;
      last_en = cpu_en;
    end
  endtask

  task automatic wait_en(input string tag, input int limit);
    int g;
    g = 0;
    do begin
      cycles(1);
      g++;
    end while (!cpu_en && g < limit);
    check(tag, int'(cpu_en), 1);
  endtask

  function automatic int exp_icount();
`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    return g_en - (last_en ? 1 : 0);
`else
    return 0;
`endif
  endfunction

  initial begin
    rst_n     = 1'b0;
    div_sel   = 2'd3;
    step_mode = 1'b0;
    step_btn  = 1'b0;
    go_btn    = 1'b0;
    halt_in   = 1'b0;

    cycles(4);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_scan_en", int'(scan_en), 0);
    check("rst_state", int'(state_o), 0);
    check("rst_icount", int'(instr_count), 0);

    // Free run at DIV3=4
    rst_n = 1'b1;
    cycles(40);
    check("free_pulses", win_pulses, 10);
    check("free_first", win_first, 4);
    check("free_scan", win_scan, 8);
    step_mode = 1'b1;
    cycles(5);
    check("free_icount", int'(instr_count), exp_icount());
    check("to_step_pulses", win_pulses, 0);
    check("to_step_state", int'(state_o), 1);

    // Single step
    step_btn = 1'b1;
    cycles(10);
    check("step_pulses", win_pulses, 1);
    check("step_latency", win_first, 6);
    step_btn = 1'b0;
    cycles(10);
    check("step_release", win_pulses, 0);
    step_btn = 1'b1;
    cycles(2);
    p = win_pulses;
    step_btn = 1'b0;
    cycles(10);
    check("bounce_pulses", p + win_pulses, 0);

    // Halt on the 3rd enable, with an earlier halt glitch between enables
    step_mode = 1'b0;
    wait_en("halt_en1", 40);
    cycles(1);
    halt_in = 1'b1;
    cycles(1);
    halt_in = 1'b0;
    check("glitch_state", int'(state_o), 0);
    wait_en("halt_en2", 20);
    wait_en("halt_en3", 20);
    halt_in = 1'b1;
    cycles(1);
    halt_in = 1'b0;
    check("halt_state", int'(state_o), 2);
    cycles(20);
    p = win_pulses;
    step_btn = 1'b1;
    cycles(10);
    p += win_pulses;
    step_btn = 1'b0;
    cycles(20);
    check("halt_no_en", p + win_pulses, 0);
    check("halt_hold_state", int'(state_o), 2);
    check("halt_icount", int'(instr_count), exp_icount());

    // Resume with halt_in still asserted for the syscall instruction
    go_btn  = 1'b1;
    halt_in = 1'b1;
    cycles(6);
    check("go_pulses", win_pulses, 1);
    check("go_latency", win_first, 6);
    cycles(1);
    p = win_pulses;
    halt_in = 1'b0;
    cycles(1);
    go_btn = 1'b0;
    check("go_extra", p + win_pulses, 0);
    check("go_state", int'(state_o), 0);
    cycles(10);
    check("resume_pulses", win_pulses, 3);
    check("resume_first", win_first, 2);

    // Rate change 3 -> 2; synchronised change lands when div_cnt is 2
    div_sel = 2'd2;
    cycles(10);
    check("rate_pulses", win_pulses, 1);
    check("rate_first", win_first, 9);
    cycles(12);
    check("div2_pulses", win_pulses, 2);
    check("div2_first", win_first, 5);

    // Async reset during a cpu_en pulse, off the clock edge
    div_sel = 2'd3;
    wait_en("rst_wait_en", 40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cpu_en", int'(cpu_en), 0);
    check("arst_scan_en", int'(scan_en), 0);
    check("arst_icount", int'(instr_count), 0);
    g_en    = 0;
    last_en = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(8);
    check("arst_first", win_first, 4);
    check("arst_pulses", win_pulses, 2);
    check("arst_scan", win_scan, 1);

    // Go and step together while halted in step mode
    halt_in = 1'b1;
    cycles(1);
    halt_in = 1'b0;
    check("sim_halt_state", int'(state_o), 2);
    step_mode = 1'b1;
    cycles(3);
    go_btn   = 1'b1;
    step_btn = 1'b1;
    cycles(8);
    p = win_pulses;
    check("sim_first", win_first, 6);
    go_btn   = 1'b0;
    step_btn = 1'b0;
    cycles(10);
    check("sim_pulses", p + win_pulses, 1);
    check("sim_state", int'(state_o), 1);
    check("final_icount", int'(instr_count), exp_icount());
    check("no_back_to_back", n_consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Upstream timing and stepping stage for the single-cycle MIPS core. Runs on the fast board clock and produces the one-cycle CPU step enable (`cpu_en`) and the seven-segment scan enable (`scan_en`).
- Supports free-run mode at a selectable rate and single-step mode from a debounced button.
- Honours the syscall halt from the core: execution stops after a halt and resumes only on a debounced `go` press.

Parameters:
- DIV0, 50_000_000, run-mode divide ratio for div_sel=0 (clk cycles per cpu_en)
- DIV1, 5_000_000, divide ratio for div_sel=1
- DIV2, 500_000, divide ratio for div_sel=2
- DIV3, 4, divide ratio for div_sel=3
- SCAN_DIV, 100_000, clk cycles per scan_en pulse
- DEB_CYCLES, 1_000_000, clk cycles a raw button level must hold stable to be accepted

Ports:
- clk  in  1  board clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- div_sel  in  2  run-rate select (asynchronous switch input, synchronised internally)
- step_mode  in  1  1 = single-step, 0 = free-run (asynchronous switch input, synchronised internally)
- step_btn  in  1  raw step push-button, active-high
- go_btn  in  1  raw resume push-button, active-high
- halt_in  in  1  halt from the syscall decoder for the instruction currently at PC
- cpu_en  out  1  one-clk pulse; the core advances exactly one instruction per pulse
- scan_en  out  1  one-clk pulse every SCAN_DIV clk cycles
- state_o  out  2  00 RUN, 01 WAIT_STEP, 10 HALTED
- instr_count  out  32  cpu_en pulses since reset (optional feature)

Behaviour:
- Reset (async, rst_n=0) values:
  - cpu_en=0, scan_en=0, instr_count=0, all counters 0.
  - state = RUN if the synchronised step_mode is 0, WAIT_STEP otherwise; since rst_n is async, the synchroniser output at deassertion decides.
- Button and switch synchronisation:
  - step_mode and div_sel each pass through a 2-FF synchroniser.
  - Each button passes through btn_debounce, which yields one rise pulse per accepted press.
  - Press-to-pulse latency is 2 + DEB_CYCLES clk cycles.
- Divider:
  - div_cnt counts 0..DIVn-1, where n is the synchronised div_sel.
  - cpu_en is asserted on the clk where div_cnt==DIVn-1 and state==RUN; div_cnt then wraps to 0.
  - Any change of the synchronised div_sel clears div_cnt on the next clk; no pulse is issued on that clk.
  - A DIV value of 1 means cpu_en is high on every clk while in RUN.
- State machine:
  - RUN
    - Issues divider pulses.
    - If cpu_en=1 and halt_in=1 on the same clk → HALTED. The syscall's own enable is issued, but the core's PC holds because its halt logic blocks the increment.
    - If step_mode=1 → WAIT_STEP; div_cnt is cleared.
  - WAIT_STEP
    - A step pulse → cpu_en for exactly one clk, registered, on the clk after the pulse.
    - If halt_in=1 on that cpu_en clk → HALTED.
    - If step_mode=0 → RUN; div_cnt starts from 0.
  - HALTED
    - No cpu_en except on resume.
    - A go pulse → one cpu_en, asserted together with a go indication that the core has consumed by then, so the PC passes the syscall. Next state is RUN or WAIT_STEP per step_mode.
    - step_btn is ignored while HALTED.
- Simultaneous events:
  - A go pulse and a step pulse on the same clk: go wins.
  - A step_mode change on the same clk as a go pulse: the new mode is used for the exit target.
- halt_in is only sampled on cpu_en clks; a glitch between enables has no effect.
- scan_en runs independently of state and of reset release order; its free counter wraps at SCAN_DIV-1.
- cpu_en is never high on two consecutive clks, except in RUN with DIVn=1.

Optional Feature:
- Macro: CPU_CLOCK_CTRL_CYCLE_COUNT_EN.
- Defined:
  - instr_count increments on every cpu_en clk and saturates at 32'hFFFF_FFFF (no wrap).
  - It is cleared only by rst_n.
- Undefined:
  - instr_count is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package cpu_clk_pkg:
  - state encoding constants ST_RUN=2'b00, ST_WAIT_STEP=2'b01, ST_HALTED=2'b10
  - the 32-bit divider width constant
- One sub-module, btn_debounce:
  - parameter DEB_CYCLES
  - ports clk, rst_n, btn_raw, btn_level, btn_rise
  - contents: 2-FF synchroniser, stability counter, and rising-edge pulse
  - instantiated twice, once for step_btn and once for go_btn.

Test Plan:
All scenarios use DIV3=4, DEB_CYCLES=3 and SCAN_DIV=5.
- Free-run: div_sel=3, step_mode=0, 40 clk → cpu_en pulses on every 4th clk (10 pulses); with the macro defined, instr_count=10.
- Step: step_mode=1, step_btn held high 10 clk → exactly one cpu_en, 6 clk after the button rises (2 sync + 3 debounce + 1 registered); a bounce held only 2 clk produces no pulse.
- Halt and resume:
  - halt_in=1 on the 3rd cpu_en → state_o=10 and no further cpu_en over 50 clk.
  - A go press → one cpu_en, then state_o=00 and pulses resume every 4 clk.
- Rate change mid-count: switch div_sel 3→2 while div_cnt=2 → div_cnt clears; the next pulse follows the DIV2 spacing.
- Async reset: drop rst_n mid-count on a non-clock edge → cpu_en=0, scan_en=0 and instr_count=0 immediately; after release, the first cpu_en arrives 4 clk later.
- Simultaneous go and step pulses in HALTED, with step_mode=1 → exactly one cpu_en, then state_o=01.
